// File: rtl/simple_ram_arbiter.sv
// Two-requester arbiter and sequencer for the single-port simpleRAM word memory.
// Optional build macro SIMPLE_RAM_ARBITER_FIXED_PRIORITY_EN: requester 0 always wins ties (default round-robin).
module simple_ram_arbiter #(
  parameter int wordSize    = 8,
  parameter int addressSize = 32,
  parameter int addrWidth   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_we,
  input  logic [2*addrWidth-1:0]   req_addr,
  input  logic [2*wordSize-1:0]    req_wdata,
  output logic [1:0]               rsp_valid,
  input  logic [1:0]               rsp_ready,
  output logic [wordSize-1:0]      rsp_rdata,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic [addrWidth-1:0]     mem_addr,
  output logic [wordSize-1:0]      mem_wdata,
  input  logic [wordSize-1:0]      mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

  localparam logic [31:0] depth = 32'(addressSize);

  state_e                 state_q, state_d;
  logic                   grant;
  logic                   handshake;
  logic                   gnt_q;
  logic                   we_q;
  logic                   weSel;
  logic [addrWidth-1:0]   addrSel;
  logic [addrWidth-1:0]   addrWrap;
  logic [wordSize-1:0]    wdataSel;
  logic                   mem_we_q, mem_re_q;
  logic [addrWidth-1:0]   mem_addr_q;
  logic [wordSize-1:0]    mem_wdata_q;
  logic [wordSize-1:0]    rsp_rdata_q;
`ifndef SIMPLE_RAM_ARBITER_FIXED_PRIORITY_EN
  logic                   last_grant_q;
`endif

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b10) begin
      grant = 1'b1;
    end else if (req_valid == 2'b11) begin
`ifdef SIMPLE_RAM_ARBITER_FIXED_PRIORITY_EN
      grant = 1'b0;
`else
      grant = ~last_grant_q;
`endif
    end
  end

  always_comb begin
    weSel    = grant ? req_we[1] : req_we[0];
    addrSel  = grant ? req_addr[2*addrWidth-1:addrWidth] : req_addr[addrWidth-1:0];
    wdataSel = grant ? req_wdata[2*wordSize-1:wordSize] : req_wdata[wordSize-1:0];
    addrWrap = addrWidth'(32'(addrSel) % depth);
  end

  assign handshake = |(req_ready & req_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by rst so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (!rst) begin
      case (state_q)
        IDLE:    if (|req_valid) req_ready[grant] = 1'b1;
        RESP:    rsp_valid[gnt_q] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      if (handshake) begin
        gnt_q       <= grant;
        we_q        <= weSel;
        mem_we_q    <= weSel;
        mem_re_q    <= ~weSel;
        mem_addr_q  <= addrWrap;
        mem_wdata_q <= wdataSel;
      end
      if (state_q == CAPTURE) begin
        rsp_rdata_q <= mem_rdata;
      end
    end
  end

`ifndef SIMPLE_RAM_ARBITER_FIXED_PRIORITY_EN
  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (handshake) begin
      last_grant_q <= grant;
    end
  end
`endif

  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
